led_breathe: RTL and testbench
==============================

Name: led_breathe

Overview:
- Downstream stage of the blink divider. Consumes the slow toggling divider output and drives a "breathing" LED.
- The LED brightness ramps up, holds, ramps down and holds again, advancing one step per transition of the slow input.
- Brightness is rendered as a free-running PWM on the fast clock.
- Sits between the blink divider output and the user-area GPIO output driver.

Parameters:
- PWM_WIDTH, 8, width of the PWM counter and duty registers; period = 2^PWM_WIDTH clocks
- STEP, 1, duty increment/decrement applied per step event
- HOLD_STEPS, 4, number of step events spent in each hold state (1..255)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  block enable; low forces IDLE
- tick  input  1  slow level input from the blink divider; every transition (rise or fall) is one step event
- led  output  1  PWM output to the pad
- duty  output  PWM_WIDTH  current target duty
- state  output  3  FSM state: 0 IDLE, 1 RAMP_UP, 2 HOLD_HIGH, 3 RAMP_DOWN, 4 HOLD_LOW
- period_done  output  1  one-cycle pulse at each PWM period wrap

Behaviour:
- Reset is asynchronous, active-high, and fixed as stated above. While rst is high:
  - led=0, duty=0, state=IDLE, period_done=0.
  - PWM counter=0, active duty=0, hold counter=0, tick_q=0.
- Step event: tick is registered into tick_q each cycle. evt = (tick != tick_q) is combinational on the registered side. FSM and duty updates on evt take effect at the next clock edge.
- PWM counter:
  - Increments every cycle while enable=1 and wraps from all-ones to 0.
  - period_done=1 in the cycle the counter equals all-ones.
  - With enable=0 the counter is held at 0.
- Glitch-free duty: active duty loads from duty only on the clock edge where the counter wraps to 0.
- led is registered: led <= enable & (pwm_ctr < active_duty).
  - active_duty=0 gives a constant 0.
  - The maximum duty gives (2^W-1)/2^W high time.
- FSM transitions:
  - IDLE: when enable=1, go to RAMP_UP next cycle with duty=0.
  - RAMP_UP: on evt, duty <= min(duty+STEP, 2^W-1), using a saturating add at W+1 bits. When the new duty equals the max, go to HOLD_HIGH and clear the hold counter.
  - HOLD_HIGH: on evt, increment the hold counter. On the HOLD_STEPSth event, go to RAMP_DOWN.
  - RAMP_DOWN: on evt, duty <= max(duty-STEP, 0), with no underflow. When the new duty is 0, go to HOLD_LOW and clear the hold counter.
  - HOLD_LOW: behaves like HOLD_HIGH, then goes to RAMP_UP.
- Boundaries and priorities:
  - enable=0 in any state: next cycle state=IDLE, duty=0, active duty=0, PWM counter=0, led=0. This has priority over evt.
  - An evt in the same cycle as enable falling is discarded.
  - tick is not synchronised inside the block. It must be synchronous to clk; the divider output is.
  - rst asserted mid-ramp returns everything to reset values immediately.

Optional Feature:
- Macro: LED_BREATHE_GAMMA_EN.
- When defined: active duty loads (duty*duty) >> PWM_WIDTH instead of duty, giving perceptually linear brightness. The load still happens only at the wrap. The duty output still shows the linear value.
- When undefined: linear mapping and no multiplier.

Test Plan:
- Set PWM_WIDTH=4, STEP=4, HOLD_STEPS=2, then assert and release rst with enable=1 -> state goes 0 then 1 after one cycle; led=0; period_done pulses every 16 cycles.
- Toggle tick 4 times, 40 cycles apart -> duty goes 4, 8, 12, 15 (saturated); state=2 after the 4th event; led high 15 of every 16 cycles after the next wrap.
- Apply 2 more events, then 4 events -> state=3 after the 2nd; duty goes 11, 7, 3, 0; state=4; led constantly 0.
- Change duty mid-period with the PWM counter at 5 -> led pattern for the current period is unchanged; the new duty applies from counter=0.
- Drop enable while in state 1 with duty=8, with a tick toggle in the same cycle -> next cycle state=0, duty=0, led=0; the event is ignored.
- With LED_BREATHE_GAMMA_EN defined, PWM_WIDTH=4, duty=8 -> active duty 4, led high 4 of 16 cycles.

Source files
------------

// File: rtl/led_breathe.sv
// Breathing-LED stage: ramps a PWM duty up/hold/down/hold, one step per tick transition.
// Optional LED_BREATHE_GAMMA_EN squares the duty before it reaches the PWM comparator.
module led_breathe #(
    parameter int PWM_WIDTH  = 8,
    parameter int STEP       = 1,
    parameter int HOLD_STEPS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 tick,
    output logic                 led,
    output logic [PWM_WIDTH-1:0] duty,
    output logic [2:0]           state,
    output logic                 period_done
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RAMP_UP   = 3'd1;
    localparam logic [2:0] S_HOLD_HIGH = 3'd2;
    localparam logic [2:0] S_RAMP_DOWN = 3'd3;
    localparam logic [2:0] S_HOLD_LOW  = 3'd4;

    localparam logic [PWM_WIDTH:0] STEP_X     = (PWM_WIDTH+1)'(STEP);
    localparam logic [PWM_WIDTH:0] DUTY_MAX_X = {1'b0, {PWM_WIDTH{1'b1}}};
    localparam logic [7:0]         HOLD_LAST  = 8'(HOLD_STEPS);

    logic                 tick_q, tick_d;
    logic [2:0]           state_q, state_d;
    logic [PWM_WIDTH-1:0] duty_q, duty_d;
    logic [7:0]           hold_q, hold_d;
    logic [PWM_WIDTH-1:0] pwm_ctr_q, pwm_ctr_d;
    logic [PWM_WIDTH-1:0] active_duty_q, active_duty_d;
    logic                 led_q, led_d;

    logic                 evt;
    logic                 wrap;
    logic [PWM_WIDTH:0]   duty_sum;
    logic [PWM_WIDTH:0]   duty_diff;
    logic [7:0]           hold_inc;
    logic [PWM_WIDTH-1:0] duty_lum;

    assign evt       = (tick != tick_q);
    assign wrap      = (pwm_ctr_q == '1);
    assign duty_sum  = {1'b0, duty_q} + STEP_X;
    assign duty_diff = {1'b0, duty_q} - STEP_X;
    assign hold_inc  = hold_q + 8'd1;

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_WIDTH-1:0] duty_sq;
    assign duty_sq  = {{PWM_WIDTH{1'b0}}, duty_q} * {{PWM_WIDTH{1'b0}}, duty_q};
    assign duty_lum = duty_sq[2*PWM_WIDTH-1:PWM_WIDTH];
`else
    assign duty_lum = duty_q;
`endif

    always_comb begin
        tick_d = tick;
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        // enable low wins over any step event arriving in the same cycle
        if (!enable) begin
            state_d = S_IDLE;
            duty_d  = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RAMP_UP;
                    duty_d  = '0;
                    hold_d  = '0;
                end
                S_RAMP_UP: begin
                    if (evt) begin
                        if (duty_sum >= DUTY_MAX_X) begin
                            duty_d  = '1;
                            state_d = S_HOLD_HIGH;
                            hold_d  = '0;
                        end else begin
                            duty_d = duty_sum[PWM_WIDTH-1:0];
                        end
                    end
                end
                S_HOLD_HIGH: begin
                    if (evt) begin
                        if (hold_inc == HOLD_LAST) begin
                            state_d = S_RAMP_DOWN;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                end
                S_RAMP_DOWN: begin
                    if (evt) begin
                        if ({1'b0, duty_q} <= STEP_X) begin
                            duty_d  = '0;
                            state_d = S_HOLD_LOW;
                            hold_d  = '0;
                        end else begin
                            duty_d = duty_diff[PWM_WIDTH-1:0];
                        end
                    end
                end
                S_HOLD_LOW: begin
                    if (evt) begin
                        if (hold_inc == HOLD_LAST) begin
                            state_d = S_RAMP_UP;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    duty_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        pwm_ctr_d     = enable ? pwm_ctr_q + 1'b1 : '0;
        // duty only reaches the comparator at the wrap, so a period is never cut short
        active_duty_d = !enable ? '0 : (wrap ? duty_lum : active_duty_q);
        led_d         = enable & (pwm_ctr_q < active_duty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q        <= 1'b0;
            state_q       <= S_IDLE;
            duty_q        <= '0;
            hold_q        <= '0;
            pwm_ctr_q     <= '0;
            active_duty_q <= '0;
            led_q         <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            state_q       <= state_d;
            duty_q        <= duty_d;
            hold_q        <= hold_d;
            pwm_ctr_q     <= pwm_ctr_d;
            active_duty_q <= active_duty_d;
            led_q         <= led_d;
        end
    end

    assign led         = led_q;
    assign duty        = duty_q;
    assign state       = state_q;
    assign period_done = wrap;

endmodule

// File: tb/tb_led_breathe.sv
// Self-checking bench for led_breathe (PWM_WIDTH=4, STEP=4, HOLD_STEPS=2).
module tb_led_breathe;

    localparam int W    = 4;
    localparam int STEP = 4;
    localparam int HOLD = 2;
    localparam int P    = 16;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         enable = 1'b1;
    logic         tick   = 1'b0;
    logic         led;
    logic         period_done;
    logic [W-1:0] duty;
    logic [2:0]   state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_breathe #(.PWM_WIDTH(W), .STEP(STEP), .HOLD_STEPS(HOLD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick),
        .led(led), .duty(duty), .state(state), .period_done(period_done)
    );

    // Reference model: one PWM period of 16 slots, brightness walk as plain integers.
    typedef struct {
        int st;
        int du;
        int ho;
        int ctr;
        int act;
        bit ld;
        bit tq;
    } mdl_t;

    mdl_t m = '{default: 0};

    function automatic int lum(input int d);
`ifdef LED_BREATHE_GAMMA_EN
        return (d * d) / P;
`else
        return d;
`endif
    endfunction

    function automatic mdl_t model_next(input mdl_t c, input bit en, input bit tk);
        mdl_t n;
        bit   ev;
        n  = c;
        ev = (tk != c.tq);
        if (!en) begin
            n.st = 0; n.du = 0; n.ho = 0;
        end else begin
            case (c.st)
                0: begin n.st = 1; n.du = 0; n.ho = 0; end
                1: if (ev) begin
                    n.du = (c.du + STEP > P - 1) ? P - 1 : c.du + STEP;
                    if (n.du == P - 1) begin n.st = 2; n.ho = 0; end
                end
                2: if (ev) begin
                    n.ho = c.ho + 1;
                    if (n.ho == HOLD) begin n.st = 3; n.ho = 0; end
                end
                3: if (ev) begin
                    n.du = (c.du - STEP < 0) ? 0 : c.du - STEP;
                    if (n.du == 0) begin n.st = 4; n.ho = 0; end
                end
                4: if (ev) begin
                    n.ho = c.ho + 1;
                    if (n.ho == HOLD) begin n.st = 1; n.ho = 0; end
                end
                default: n.st = 0;
            endcase
        end
        n.ld  = en && (c.ctr < c.act);
        n.act = !en ? 0 : ((c.ctr == P - 1) ? lum(c.du) : c.act);
        n.ctr = en ? (c.ctr + 1) % P : 0;
        n.tq  = tk;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{default: 0};
        else     m <= model_next(m, enable, tick);
    end

    // Align to the negedge where the counter reads 1, then count led over one full period.
    task automatic measure_period(output int highs, output bit ok);
        int guard;
        highs = 0;
        ok    = 1'b0;
        guard = 0;
        while (m.ctr != 1 && guard < 2 * P) begin
            @(negedge clk);
            guard++;
        end
        if (m.ctr == 1) begin
            ok = 1'b1;
            for (int i = 0; i < P; i++) begin
                if (led === 1'b1) highs++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; tick = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL reset_led: got %b want 0", led); end
        n_cmp++; if (duty !== 4'd0) begin n_bad++; $display("FAIL reset_duty: got %0d want 0", duty); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (period_done !== 1'b0) begin n_bad++; $display("FAIL reset_pd: got %b want 0", period_done); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL reset_to_rampup: got %0d want 1", state); end
        for (int k = 2; k < 50; k++) begin
            @(negedge clk);
            n_cmp++;
            if (period_done !== ((k % P) == P - 1)) begin
                n_bad++; $display("FAIL period_done k=%0d: got %b want %b", k, period_done, (k % P) == P - 1);
            end
            n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL idle_led k=%0d: got %b want 0", k, led); end
        end
    endtask

    task automatic test_ramp_up();
        int exp_d [4] = '{4, 8, 12, 15};
        int exp_s [4] = '{1, 1, 1, 2};
        int highs;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            tick = ~tick;
            @(negedge clk);
            n_cmp++; if (duty !== 4'(exp_d[i])) begin n_bad++; $display("FAIL ramp_up_duty[%0d]: got %0d want %0d", i, duty, exp_d[i]); end
            n_cmp++; if (state !== 3'(exp_s[i])) begin n_bad++; $display("FAIL ramp_up_state[%0d]: got %0d want %0d", i, state, exp_s[i]); end
            repeat (39) @(negedge clk);
        end
        measure_period(highs, ok);
        n_cmp++; if (!ok || highs != lum(15)) begin n_bad++; $display("FAIL full_duty_highs: got %0d want %0d (aligned=%b)", highs, lum(15), ok); end
    endtask

    task automatic test_ramp_down();
        int exp_d [6] = '{15, 15, 11, 7, 3, 0};
        int exp_s [6] = '{2, 3, 3, 3, 3, 4};
        int highs;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            tick = ~tick;
            @(negedge clk);
            n_cmp++; if (duty !== 4'(exp_d[i])) begin n_bad++; $display("FAIL ramp_down_duty[%0d]: got %0d want %0d", i, duty, exp_d[i]); end
            n_cmp++; if (state !== 3'(exp_s[i])) begin n_bad++; $display("FAIL ramp_down_state[%0d]: got %0d want %0d", i, state, exp_s[i]); end
            repeat (39) @(negedge clk);
        end
        measure_period(highs, ok);
        n_cmp++; if (!ok || highs != 0) begin n_bad++; $display("FAIL zero_duty_highs: got %0d want 0 (aligned=%b)", highs, ok); end
    endtask

    task automatic test_mid_period();
        int exp_s [2] = '{4, 1};
        int highs;
        int guard;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            tick = ~tick;
            @(negedge clk);
            n_cmp++; if (state !== 3'(exp_s[i])) begin n_bad++; $display("FAIL hold_low_state[%0d]: got %0d want %0d", i, state, exp_s[i]); end
            repeat (20) @(negedge clk);
        end
        guard = 0;
        while (m.ctr != 4 && guard < 2 * P) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++; if (m.ctr != 4) begin n_bad++; $display("FAIL mid_align: got ctr %0d want 4", m.ctr); end
        tick = ~tick;
        @(negedge clk);
        n_cmp++; if (duty !== 4'd4) begin n_bad++; $display("FAIL mid_duty: got %0d want 4", duty); end
        highs = 0;
        guard = 0;
        while (guard < P) begin
            if (led === 1'b1) highs++;
            if (m.ctr == 0) break;
            @(negedge clk);
            guard++;
        end
        n_cmp++; if (highs != 0) begin n_bad++; $display("FAIL mid_current_period: got %0d highs want 0", highs); end
        measure_period(highs, ok);
        n_cmp++; if (!ok || highs != lum(4)) begin n_bad++; $display("FAIL mid_next_period: got %0d highs want %0d", highs, lum(4)); end
    endtask

    task automatic test_enable_drop();
        int highs;
        bit ok;
        tick = ~tick;
        @(negedge clk);
        n_cmp++; if (duty !== 4'd8) begin n_bad++; $display("FAIL pre_drop_duty: got %0d want 8", duty); end
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL pre_drop_state: got %0d want 1", state); end
        repeat (20) @(negedge clk);
        measure_period(highs, ok);
        n_cmp++; if (!ok || highs != lum(8)) begin n_bad++; $display("FAIL duty8_highs: got %0d want %0d", highs, lum(8)); end
        enable = 1'b0;
        tick   = ~tick;
        @(negedge clk);
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL drop_state: got %0d want 0", state); end
        n_cmp++; if (duty !== 4'd0) begin n_bad++; $display("FAIL drop_duty: got %0d want 0", duty); end
        n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL drop_led: got %b want 0", led); end
        enable = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL reenable_state: got %0d want 1", state); end
        repeat (20) @(negedge clk);
        n_cmp++; if (duty !== 4'd0) begin n_bad++; $display("FAIL discarded_evt_duty: got %0d want 0", duty); end
        n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL reenable_led: got %b want 0", led); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            tick = ~tick;
            repeat (25) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (duty !== 4'd0) begin n_bad++; $display("FAIL midrst_duty: got %0d want 0", duty); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", state); end
        n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL midrst_led: got %b want 0", led); end
        n_cmp++; if (period_done !== 1'b0) begin n_bad++; $display("FAIL midrst_pd: got %b want 0", period_done); end
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL post_midrst_state: got %0d want 1", state); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_cmp++; if (led !== m.ld) begin n_bad++; $display("FAIL rand_led cyc=%0d: got %b want %b", i, led, m.ld); end
            n_cmp++; if (duty !== 4'(m.du)) begin n_bad++; $display("FAIL rand_duty cyc=%0d: got %0d want %0d", i, duty, m.du); end
            n_cmp++; if (state !== 3'(m.st)) begin n_bad++; $display("FAIL rand_state cyc=%0d: got %0d want %0d", i, state, m.st); end
            n_cmp++; if (period_done !== (m.ctr == P - 1)) begin n_bad++; $display("FAIL rand_pd cyc=%0d: got %b want %b", i, period_done, m.ctr == P - 1); end
            if ($urandom_range(0, 9) == 0) tick = ~tick;
            if (enable) begin
                if ($urandom_range(0, 299) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 4) == 0) enable = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_mid_period();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
